// File: rtl/data_ram_arbiter.sv
// Two-port arbiter and little-endian byte sequencer for the byte-wide synchronous data RAM.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the MEM port wins ties.
module data_ram_arbiter #(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_vbit,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  typedef enum logic [1:0] {StIdle, StXfer, StLast, StDone} state_e;

  state_e            state_q, state_d;
  logic              sel_mem_q;
  logic              we_q;
  logic [1:0]        cnt_q;
  logic [1:0]        last_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;
  logic [3:0][7:0]   rbuf_q;
  logic [3:0][7:0]   rd_word;
  logic [31:0]       if_rdata_q;
  logic [31:0]       mem_rdata_q;

  logic grant_any;
  logic grant_mem;
  logic mem_wins_tie;
  logic [1:0] mem_last_idx;

  assign grant_any = if_req | mem_req;
  assign grant_mem = mem_req & (~if_req | mem_wins_tie);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_mem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_mem_q <= 1'b0;
    end else if (state_q == StIdle && grant_any) begin
      last_mem_q <= grant_mem;
    end
  end

  assign mem_wins_tie = ~last_mem_q;
`else
  assign mem_wins_tie = 1'b1;
`endif

  // Index of the final byte for each access size (size 00 never reaches XFER).
  always_comb begin
    mem_last_idx = 2'd0;
    unique case (mem_vbit)
      2'b10:   mem_last_idx = 2'd1;
      2'b11:   mem_last_idx = 2'd3;
      default: mem_last_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_any) begin
          state_d = (grant_mem && mem_vbit == 2'b00) ? StDone : StXfer;
        end
      end
      StXfer: begin
        if (cnt_q == last_q) begin
          state_d = we_q ? StDone : StLast;
        end
      end
      StLast: state_d = StDone;
      StDone: state_d = StIdle;
    endcase
  end

  // The last read byte arrives during LAST, so merge it straight from the RAM bus.
  always_comb begin
    rd_word         = rbuf_q;
    rd_word[last_q] = ram_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sel_mem_q   <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= 2'd0;
      last_q      <= 2'd0;
      base_q      <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (grant_any) begin
            sel_mem_q <= grant_mem;
            cnt_q     <= 2'd0;
            rbuf_q    <= '0;
            if (grant_mem) begin
              we_q    <= mem_we;
              base_q  <= mem_addr;
              wdata_q <= mem_wdata;
              last_q  <= mem_last_idx;
            end else begin
              we_q    <= 1'b0;
              base_q  <= if_addr;
              wdata_q <= '0;
              last_q  <= 2'd3;
            end
          end
        end
        StXfer: begin
          cnt_q <= cnt_q + 2'd1;
          if (!we_q && cnt_q != 2'd0) begin
            rbuf_q[cnt_q - 2'd1] <= ram_rdata;
          end
        end
        StLast: begin
          if (sel_mem_q) begin
            mem_rdata_q <= rd_word;
          end else begin
            if_rdata_q <= rd_word;
          end
        end
        StDone: ;
      endcase
    end
  end

  assign ram_ce    = (state_q == StXfer);
  assign ram_we    = ram_ce & we_q;
  assign ram_addr  = ram_ce ? base_q + ADDR_W'(cnt_q) : '0;
  assign ram_wdata = ram_ce ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'h00;

  assign if_done   = (state_q == StDone) & ~sel_mem_q;
  assign mem_done  = (state_q == StDone) & sel_mem_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Bench for data_ram_arbiter: directed vector table, tie/reset sequences, and randomized
// traffic checked against a byte-array memory model.
module tb_data_ram_arbiter;

  localparam int unsigned AW = 17;
  localparam int unsigned MEMSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, mem_req, mem_we;
  logic [AW-1:0] if_addr, mem_addr;
  logic [1:0]    mem_vbit;
  logic [31:0]   mem_wdata, if_rdata, mem_rdata;
  logic          if_done, mem_done;
  logic          ram_ce, ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata = 8'h00;

  int checks = 0;
  int errors = 0;
  int ce_cnt = 0;

  logic [7:0] ram     [MEMSZ];
  logic [7:0] ref_mem [MEMSZ];

  logic [31:0] exp_mem_rd;
  logic [31:0] exp_if_rd;

  data_ram_arbiter #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_vbit  (mem_vbit),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .ram_ce    (ram_ce),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM: read data valid one cycle after the address.
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) ram[ram_addr] = ram_wdata;
      ram_rdata <= ram[ram_addr];
      ce_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int size_n(input logic [1:0] vb);
    case (vb)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [AW-1:0] a, input int n);
    logic [31:0] v = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_mem[AW'(a + AW'(k))]) << (8 * k));
    return v;
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input int n, input logic [31:0] wd);
    for (int k = 0; k < n; k++) ref_mem[AW'(a + AW'(k))] = wd[8*k +: 8];
  endtask

  function automatic int exp_latency(input bit we, input int n);
    if (n == 0) return 1;
    return we ? n + 1 : n + 2;
  endfunction

  // Starts just after a rising edge with the DUT idle; lat = cycle of the done pulse.
  task automatic do_op(input bit is_mem, input logic we, input logic [1:0] vb,
                       input logic [AW-1:0] a, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output int ces);
    ce_cnt = 0;
    if (is_mem) begin
      mem_req = 1'b1; mem_we = we; mem_vbit = vb; mem_addr = a; mem_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = a;
    end
    lat = -1;
    rd  = 32'h0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (is_mem ? mem_done : if_done) begin
        lat = c;
        rd  = is_mem ? mem_rdata : if_rdata;
        break;
      end
      @(posedge clk); #1;
    end
    ces = ce_cnt;
    @(posedge clk); #1;
    mem_req = 1'b0;
    if_req  = 1'b0;
  endtask

  task automatic tie(input bit exp_mem_first, input string tag);
    bit          seen, first_mem, both, repeat_win;
    logic [31:0] rd;
    if_req = 1'b1; if_addr = 17'h10;
    mem_req = 1'b1; mem_we = 1'b0; mem_vbit = 2'b01; mem_addr = 17'h12;
    seen = 0; first_mem = 0; both = 0; repeat_win = 0; rd = 32'h0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_done || if_done) begin
        seen = 1; first_mem = mem_done; both = mem_done && if_done;
        rd = mem_done ? mem_rdata : if_rdata;
        break;
      end
      @(posedge clk); #1;
    end
    chk({tag, " first done seen"}, 32'(seen), 32'd1);
    chk({tag, " winner is mem"}, 32'(first_mem), 32'(exp_mem_first));
    chk({tag, " single done"}, 32'(both), 32'd0);
    chk({tag, " winner rdata"}, rd, first_mem ? 32'h000000CC : 32'hDDCCBBAA);
    @(posedge clk); #1;
    if (first_mem) mem_req = 1'b0;
    else if_req = 1'b0;
    seen = 0; rd = 32'h0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (first_mem ? mem_done : if_done) repeat_win = 1;
      if (first_mem ? if_done : mem_done) begin
        seen = 1;
        rd = first_mem ? if_rdata : mem_rdata;
        break;
      end
      @(posedge clk); #1;
    end
    chk({tag, " loser done seen"}, 32'(seen), 32'd1);
    chk({tag, " no repeat winner done"}, 32'(repeat_win), 32'd0);
    chk({tag, " loser rdata"}, rd, first_mem ? 32'hDDCCBBAA : 32'h000000CC);
    @(posedge clk); #1;
    if_req = 1'b0; mem_req = 1'b0;
    exp_mem_rd = 32'h000000CC;
    exp_if_rd  = 32'hDDCCBBAA;
  endtask

  typedef struct {
    logic          we;
    logic [1:0]    vb;
    logic [AW-1:0] a;
    logic [31:0]   wd;
    logic [31:0]   exp_rd;
    int            exp_lat;
    int            exp_ce;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int          lat, ces;
    logic [31:0] rd;
    bit          is_mem, we;
    logic [1:0]  vb;
    logic [AW-1:0] a;
    logic [31:0] wd, erd;
    int          n;

    vecs[0]  = '{1'b1, 2'b11, 17'h00010, 32'hDDCCBBAA, 32'h00000000, 5, 4};
    vecs[1]  = '{1'b0, 2'b11, 17'h00010, 32'h00000000, 32'hDDCCBBAA, 6, 4};
    vecs[2]  = '{1'b0, 2'b01, 17'h00012, 32'h00000000, 32'h000000CC, 3, 1};
    vecs[3]  = '{1'b0, 2'b10, 17'h00011, 32'h00000000, 32'h0000CCBB, 4, 2};
    vecs[4]  = '{1'b1, 2'b11, 17'h1FFFE, 32'h44332211, 32'h0000CCBB, 5, 4};
    vecs[5]  = '{1'b0, 2'b11, 17'h1FFFE, 32'h00000000, 32'h44332211, 6, 4};
    vecs[6]  = '{1'b0, 2'b10, 17'h1FFFF, 32'h00000000, 32'h00003322, 4, 2};
    vecs[7]  = '{1'b0, 2'b00, 17'h00010, 32'h00000000, 32'h00003322, 1, 0};
    vecs[8]  = '{1'b1, 2'b01, 17'h00020, 32'h0000005A, 32'h00003322, 2, 1};
    vecs[9]  = '{1'b0, 2'b01, 17'h00020, 32'h00000000, 32'h0000005A, 3, 1};
    vecs[10] = '{1'b1, 2'b10, 17'h00030, 32'hFFFF1234, 32'h0000005A, 3, 2};
    vecs[11] = '{1'b0, 2'b11, 17'h00030, 32'h00000000, 32'h00001234, 6, 4};

    for (int i = 0; i < int'(MEMSZ); i++) begin
      ram[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_vbit = 2'b00; mem_addr = '0; mem_wdata = '0;
    #22;
    chk("reset ram_ce", 32'(ram_ce), 32'd0);
    chk("reset ram_addr", 32'(ram_addr), 32'd0);
    chk("reset mem_done", 32'(mem_done), 32'd0);
    chk("reset if_done", 32'(if_done), 32'd0);
    chk("reset mem_rdata", mem_rdata, 32'd0);
    chk("reset if_rdata", if_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      do_op(1'b1, vecs[i].we, vecs[i].vb, vecs[i].a, vecs[i].wd, lat, rd, ces);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d mem_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d ram cycles", i), 32'(ces), 32'(vecs[i].exp_ce));
      if (vecs[i].we) model_write(vecs[i].a, size_n(vecs[i].vb), vecs[i].wd);
    end
    chk("ram[0x10]", 32'(ram[17'h10]), 32'hAA);
    chk("ram[0x11]", 32'(ram[17'h11]), 32'hBB);
    chk("ram[0x12]", 32'(ram[17'h12]), 32'hCC);
    chk("ram[0x13]", 32'(ram[17'h13]), 32'hDD);
    chk("ram[0x1FFFE]", 32'(ram[17'h1FFFE]), 32'h11);
    chk("ram[0x1FFFF]", 32'(ram[17'h1FFFF]), 32'h22);
    chk("ram[0x0]", 32'(ram[17'h0]), 32'h33);
    chk("ram[0x1]", 32'(ram[17'h1]), 32'h44);
    exp_mem_rd = 32'h00001234;

    do_op(1'b0, 1'b0, 2'b11, 17'h10, 32'h0, lat, rd, ces);
    chk("fetch latency", 32'(lat), 32'd6);
    chk("fetch rdata", rd, 32'hDDCCBBAA);
    chk("fetch leaves mem_rdata", mem_rdata, exp_mem_rd);
    exp_if_rd = 32'hDDCCBBAA;

    // Two simultaneous-request ties, separated by a solo MEM grant.
    tie(1'b1, "tie1");
    do_op(1'b1, 1'b0, 2'b01, 17'h13, 32'h0, lat, rd, ces);
    chk("solo byte read", rd, 32'h000000DD);
`ifdef ARB_ROUND_ROBIN_EN
    tie(1'b0, "tie2");
`else
    tie(1'b1, "tie2");
`endif

    // Reset in the third byte of a word write.
    mem_req = 1'b1; mem_we = 1'b1; mem_vbit = 2'b11; mem_addr = 17'h40; mem_wdata = 32'hA1B2C3D4;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre-reset ram_addr", 32'(ram_addr), 32'h42);
    rst_n = 1'b0;
    #1;
    chk("async reset ram_ce", 32'(ram_ce), 32'd0);
    chk("async reset ram_we", 32'(ram_we), 32'd0);
    chk("async reset ram_addr", 32'(ram_addr), 32'd0);
    chk("async reset ram_wdata", 32'(ram_wdata), 32'd0);
    chk("async reset mem_done", 32'(mem_done), 32'd0);
    chk("async reset mem_rdata", mem_rdata, 32'd0);
    chk("async reset if_rdata", if_rdata, 32'd0);
    mem_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("partial write ram[0x40]", 32'(ram[17'h40]), 32'hD4);
    chk("partial write ram[0x41]", 32'(ram[17'h41]), 32'hC3);
    chk("partial write ram[0x42]", 32'(ram[17'h42]), 32'h00);
    model_write(17'h40, 2, 32'h0000C3D4);
    exp_mem_rd = 32'h0;
    exp_if_rd  = 32'h0;
    do_op(1'b1, 1'b0, 2'b11, 17'h40, 32'h0, lat, rd, ces);
    chk("post-reset latency", 32'(lat), 32'd6);
    chk("post-reset rdata", rd, 32'h0000C3D4);
    exp_mem_rd = 32'h0000C3D4;

    // Randomized traffic against the memory model.
    for (int i = 0; i < 80; i++) begin
      is_mem = ($urandom_range(0, 3) != 0);
      we     = is_mem ? 1'($urandom_range(0, 1)) : 1'b0;
      vb     = is_mem ? 2'($urandom_range(0, 3)) : 2'b11;
      a      = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 31))
                                           : AW'(17'h1FFF0 + AW'($urandom_range(0, 15)));
      wd     = $urandom;
      n      = size_n(vb);
      if (!is_mem) erd = model_read(a, 4);
      else if (!we && n != 0) erd = model_read(a, n);
      else erd = exp_mem_rd;
      do_op(is_mem, we, vb, a, wd, lat, rd, ces);
      chk($sformatf("rand%0d latency", i), 32'(lat), 32'(exp_latency(we, n)));
      chk($sformatf("rand%0d rdata", i), rd, erd);
      chk($sformatf("rand%0d ram cycles", i), 32'(ces), 32'(n));
      if (is_mem && we) model_write(a, n, wd);
      if (is_mem) exp_mem_rd = erd;
      else exp_if_rd = erd;
    end
    chk("final if_rdata held", if_rdata, exp_if_rd);
    chk("final mem_rdata held", mem_rdata, exp_mem_rd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_ram_arbiter.md
# data_ram_arbiter

Two-port arbiter and byte sequencer in front of the byte-wide synchronous data RAM. Shares the RAM between the instruction-fetch port (word reads) and the MEM-stage port (byte/half/word reads and writes). Each granted request is split into single-byte RAM cycles, stored little-endian, and reassembled. A one-cycle done pulse is returned to the winning requester.

## Interface
- `ADDR_W`, 17, byte address width of the RAM and both requester ports
- `clk` in 1, system clock, rising edge
- `rst_n` in 1, asynchronous active-low reset
- `if_req` in 1, fetch request; held high until `if_done`
- `if_addr` in ADDR_W, fetch byte address; held stable while `if_req` is high
- `if_rdata` out 32, assembled fetch word
- `if_done` out 1, one-cycle completion pulse for the fetch port
- `mem_req` in 1, MEM-stage request; held high until `mem_done`
- `mem_we` in 1, 1 = write, 0 = read
- `mem_vbit` in 2, access size: 00 none, 01 byte, 10 half, 11 word
- `mem_addr` in ADDR_W, MEM byte address
- `mem_wdata` in 32, write data; bits [7:0] go to the lowest address
- `mem_rdata` out 32, assembled read data, zero-extended
- `mem_done` out 1, one-cycle completion pulse for the MEM port
- `ram_ce` out 1, RAM chip enable, high on every byte cycle
- `ram_we` out 1, RAM write enable
- `ram_addr` out ADDR_W, RAM byte address
- `ram_wdata` out 8, RAM write byte
- `ram_rdata` in 8, RAM read byte, valid one cycle after its address

## Operation
- States: IDLE, XFER, LAST, DONE.
- **IDLE**
  - Requests are sampled.
  - The winner's address, size, we and wdata are latched. Size count n = 1/2/4; the fetch port is always a word read (n = 4).
  - Go to XFER. With `mem_vbit`=00, go straight to DONE with no RAM cycle.
- **XFER**
  - Byte k (k = 0..n-1) is driven for one cycle: `ram_ce`=1, `ram_addr`=base+k modulo 2^ADDR_W (wrap-around), `ram_we`=latched we, `ram_wdata`=byte k of wdata.
  - Read byte k-1 arriving on `ram_rdata` is captured into lane k-1.
  - After byte n-1: a write goes to DONE, a read goes to LAST.
- **LAST**: `ram_ce`=0; byte n-1 is captured. Go to DONE.
- **DONE**
  - The winner's done pulses for one cycle and its rdata is updated for reads (upper lanes zero).
  - Requests are ignored. Go to IDLE.
  - A requester drops `req` in the cycle after it sees done.
- Arbitration: simultaneous requests in IDLE are resolved per Configuration. The loser waits and keeps `req` high.
- `if_rdata`/`mem_rdata` hold their last value until that port's next completed read. Writes leave `mem_rdata` unchanged.
- `ram_ce`, `ram_we`, `ram_addr`, `ram_wdata` are all 0 in IDLE, LAST and DONE.

## Timing
- Request high in IDLE cycle 0; first RAM byte in cycle 1.
- Write of n bytes: RAM cycles 1..n, done in cycle n+1 (word write: done in cycle 5).
- Read of n bytes: RAM cycles 1..n, LAST in cycle n+1, done in cycle n+2 (word read: done in cycle 6; byte read: cycle 3).
- Size 00: done in cycle 1.
- Back-to-back: the next grant is evaluated in the IDLE cycle after DONE, so the minimum period is n+2 (write) or n+3 (read) cycles.
- Reset (async, any state):
  - State returns to IDLE.
  - All outputs, both rdata registers and the round-robin pointer go to 0.
  - Bytes already written stay written; the access is not resumed.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - On a tie, grant the port not granted last.
  - The last-grant register updates on every grant and resets to "fetch", so MEM wins the first tie.
- Not defined: MEM port always wins ties (fixed priority). A waiting fetch is served only when `mem_req` is low in IDLE.

## Test plan
- Word write `mem_addr`=0x10, `mem_wdata`=0xDDCCBBAA, then word read 0x10 → RAM bytes 0x10..0x13 = AA,BB,CC,DD; write done in cycle 5, read done in cycle 6 with `mem_rdata`=0xDDCCBBAA.
- Byte read at 0x12 after the write above → `mem_rdata`=0x000000CC, done in cycle 3. Half read at 0x11 → 0x0000CCBB.
- Word write at 2^ADDR_W-2 with 0x44332211 → bytes 11,22 at the top two addresses, 33,44 at addresses 0 and 1.
- `if_req` and `mem_req` raised together twice:
  - without the macro, MEM wins both times;
  - with the macro, MEM wins first and fetch wins second;
  - the loser's done never pulses early.
- `rst_n` low during the third byte of a word write → state IDLE and outputs 0 immediately; only the first two bytes are written; a new request after reset completes normally.
- `mem_vbit`=00 request → `mem_done` in cycle 1, `ram_ce` never asserted, `mem_rdata` unchanged.
